// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - packet-fetching instruction sequencer with req/ack unit handshakes
module exec_sequencer #(
  parameter int INST_W  = 32,
  parameter int IPP     = 8,
  parameter int PC_W    = 7,
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        run,
  output logic                        imem_req,
  output logic [PC_W-$clog2(IPP)-1:0] imem_addr,
  input  logic                        imem_ack,
  input  logic [INST_W*IPP-1:0]       imem_data,
  output logic                        opr_req,
  output logic                        opr_sel,
  output logic                        opr_is_reg,
  output logic [ADDR_W-1:0]           opr_addr,
  input  logic                        opr_ack,
  output logic [6:0]                  alu_op,
  output logic                        alu_start,
  input  logic                        alu_done,
  output logic                        wb_req,
  output logic                        wb_is_reg,
  output logic [ADDR_W-1:0]           wb_addr,
  input  logic                        wb_ack,
  output logic [PC_W-1:0]             pc,
  output logic                        halted,
  output logic                        fault,
  output logic [1:0]                  fault_code
);
  localparam int SLOT_W = $clog2(IPP);
  localparam int CNT_W  = $clog2(TIMEOUT + 2);
  localparam bit TO_EN  = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [6:0] OP_HALT = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RD1, S_RD2, S_EXEC, S_WB, S_FAULT
  } state_t;

  state_t                state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic                  pkt_valid_q, pkt_valid_d;
  logic [INST_W*IPP-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0]      wait_q, wait_d;
  logic                  fault_q, fault_d;
  logic [1:0]            fcode_q, fcode_d;

  logic [INST_W-1:0] slots [IPP];
  logic [SLOT_W-1:0] slot;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   pc_inc;
  logic              timed_out;
  logic              to_fault;
  logic [1:0]        to_code;

  // Slot 0 sits in the most significant bits of the packet.
  for (genvar g = 0; g < IPP; g++) begin : g_slot
    assign slots[g] = pkt_q[(IPP-1-g)*INST_W +: INST_W];
  end

  assign slot      = pc_q[SLOT_W-1:0];
  assign inst      = slots[slot];
  assign pc_inc    = pc_q + PC_W'(1);
  assign timed_out = TO_EN && (wait_q == TO_LAST);

  // Next-state logic: handshake completion wins over timeout in the same cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pkt_valid_d = pkt_valid_q;
    pkt_d       = pkt_q;
    fault_d     = fault_q;
    fcode_d     = fcode_q;
    to_fault    = 1'b0;
    to_code     = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = (!pkt_valid_q || slot == '0) ? S_FETCH : S_DECODE;
      end
      S_FETCH: begin
        if (imem_ack) begin
          pkt_d       = imem_data;
          pkt_valid_d = 1'b1;
          state_d     = S_DECODE;
        end else if (timed_out) begin
          to_fault = 1'b1;
          to_code  = 2'd0;
        end
      end
      S_DECODE: state_d = (inst[31:25] == OP_HALT) ? S_IDLE : S_RD1;
      S_RD1: begin
        if (opr_ack) state_d = inst[0] ? S_RD2 : S_EXEC;
        else if (timed_out) begin
          to_fault = 1'b1;
          to_code  = 2'd1;
        end
      end
      S_RD2: begin
        if (opr_ack) state_d = S_EXEC;
        else if (timed_out) begin
          to_fault = 1'b1;
          to_code  = 2'd1;
        end
      end
      S_EXEC: begin
        if (alu_done) state_d = S_WB;
        else if (timed_out) begin
          to_fault = 1'b1;
          to_code  = 2'd2;
        end
      end
      S_WB: begin
        if (wb_ack) begin
          pc_d    = pc_inc;
          state_d = (pc_inc[SLOT_W-1:0] == '0) ? S_FETCH : S_DECODE;
        end else if (timed_out) begin
          to_fault = 1'b1;
          to_code  = 2'd3;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (to_fault) begin
      state_d = S_FAULT;
      fault_d = 1'b1;
      fcode_d = to_code;
    end
    wait_d = (state_d != state_q) ? '0 : ((&wait_q) ? wait_q : wait_q + CNT_W'(1));
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      pkt_valid_q <= 1'b0;
      pkt_q       <= '0;
      wait_q      <= '0;
      fault_q     <= 1'b0;
      fcode_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_q       <= pkt_d;
      wait_q      <= wait_d;
      fault_q     <= fault_d;
      fcode_q     <= fcode_d;
    end
  end

  // Request and field outputs are decoded from the state; addresses read 0 outside their state.
  always_comb begin
    imem_req   = (state_q == S_FETCH);
    opr_req    = (state_q == S_RD1) || (state_q == S_RD2);
    opr_sel    = (state_q == S_RD2);
    opr_is_reg = 1'b0;
    opr_addr   = '0;
    if (state_q == S_RD1) begin
      opr_is_reg = inst[8];
      opr_addr   = ADDR_W'(inst[15:9]);
    end else if (state_q == S_RD2) begin
      opr_is_reg = inst[16];
      opr_addr   = ADDR_W'(inst[7:1]);
    end
    alu_op = '0;
    if (state_q inside {S_RD1, S_RD2, S_EXEC, S_WB}) alu_op = inst[31:25];
    alu_start = (state_q == S_EXEC) && (wait_q == '0);
    wb_req    = (state_q == S_WB);
    wb_is_reg = (state_q == S_WB) ? inst[24] : 1'b0;
    wb_addr   = (state_q == S_WB) ? ADDR_W'(inst[23:17]) : '0;
  end

  assign imem_addr  = pc_q[PC_W-1:SLOT_W];
  assign pc         = pc_q;
  assign halted     = (state_q == S_IDLE);
  assign fault      = fault_q;
  assign fault_code = fcode_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - randomized self-checking bench for exec_sequencer
module tb_exec_sequencer;
  localparam int TOUT = 4;

  logic         clock = 1'b0;
  logic         reset, run;
  logic         imem_req, imem_ack;
  logic [0:0]   imem_addr;
  logic [255:0] imem_data;
  logic         opr_req, opr_sel, opr_is_reg, opr_ack;
  logic [6:0]   opr_addr, alu_op, wb_addr;
  logic         alu_start, alu_done, wb_req, wb_is_reg, wb_ack;
  logic [3:0]   pc;
  logic         halted, fault;
  logic [1:0]   fault_code;

  exec_sequencer #(.INST_W(32), .IPP(8), .PC_W(4), .ADDR_W(7), .TIMEOUT(TOUT)) dut (
    .clock(clock), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .opr_req(opr_req), .opr_sel(opr_sel), .opr_is_reg(opr_is_reg), .opr_addr(opr_addr),
    .opr_ack(opr_ack), .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
    .wb_req(wb_req), .wb_is_reg(wb_is_reg), .wb_addr(wb_addr), .wb_ack(wb_ack),
    .pc(pc), .halted(halted), .fault(fault), .fault_code(fault_code)
  );

  always #5 clock = ~clock;

  typedef struct {int kind; int sel; int is_reg; int addr; int op;} txn_t;
  localparam logic [31:0] HALT = 32'hFE00_0000;

  txn_t         exp_q[$];
  logic [255:0] prog [2];
  logic [255:0] m_pkt;
  int m_pc, m_pkt_valid;
  int n_pass = 0, n_total = 0;
  int cyc = 0;
  int dly_max, force_rd1, force_wb, stall_kind, t_stall, t_fault;
  int busy, remain, alu_wait, remain_alu;
  int n_fetch, first_fetch_addr, last_fetch_addr, n_opr0, n_opr1, n_alu_cyc, n_rd1_cyc;
  int last_wb_addr, last_wb_is_reg;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [31:0] enc(int op, int dreg, int dest, int s2reg, int s1, int s1reg,
                                      int s2, int has2);
    return {op[6:0], dreg[0], dest[6:0], s2reg[0], s1[6:0], s1reg[0], s2[6:0], has2[0]};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    w[31:25] = 7'($urandom_range(126, 0));
    return w;
  endfunction

  task automatic set_slot(input int p, input int s, input logic [31:0] w);
    prog[p][(7-s)*32 +: 32] = w;
  endtask

  task automatic push_txn(input int kind, input int sel, input int is_reg, input int addr, input int op);
    txn_t t;
    t.kind = kind; t.sel = sel; t.is_reg = is_reg; t.addr = addr; t.op = op;
    exp_q.push_back(t);
  endtask

  // Reference model: expand a run from the current pc into its unit transactions.
  task automatic gen_run();
    int slot, pk;
    logic [31:0] w;
    for (int n = 0; n < 40; n++) begin
      slot = m_pc % 8;
      pk   = m_pc / 8;
      if (m_pkt_valid == 0 || slot == 0) begin
        push_txn(0, 0, 0, pk, 0);
        m_pkt = prog[pk];
        m_pkt_valid = 1;
      end
      w = m_pkt[(7-slot)*32 +: 32];
      if (w[31:25] == 7'h7F) break;
      push_txn(1, 0, int'(w[8]), int'(w[15:9]), int'(w[31:25]));
      if (w[0]) push_txn(1, 1, int'(w[16]), int'(w[7:1]), int'(w[31:25]));
      push_txn(2, 0, 0, 0, int'(w[31:25]));
      push_txn(3, 0, int'(w[24]), int'(w[23:17]), int'(w[31:25]));
      m_pc = (m_pc + 1) % 16;
    end
  endtask

  function automatic int pick(int kind, int sel);
    if (kind == stall_kind) begin
      t_stall = cyc;
      return 1000;
    end
    if (kind == 1 && sel == 0 && force_rd1 >= 0) return force_rd1;
    if (kind == 3 && force_wb >= 0) return force_wb;
    return int'($urandom_range(dly_max, 0));
  endfunction

  task automatic clear_stats();
    n_fetch = 0; first_fetch_addr = -1; last_fetch_addr = -1;
    n_opr0 = 0; n_opr1 = 0; n_alu_cyc = 0; n_rd1_cyc = 0;
    last_wb_addr = -1; last_wb_is_reg = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    stall_kind = -1; force_rd1 = -1; force_wb = -1;
    exp_q.delete();
    m_pc = 0; m_pkt_valid = 0;
    busy = 0; alu_wait = 0; t_fault = -1; t_stall = -1;
    clear_stats();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic start_run();
    gen_run();
    run = 1'b1;
    @(posedge clock);
    #1 run = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(posedge clock);
      #1 cycles++;
    end
    chk({tag, "_halted"}, halted, 1);
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_pc"}, pc, m_pc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_fault_code"}, fault_code, 0);
    chk({tag, "_reqs"}, {imem_req, opr_req, wb_req, alu_start}, 0);
    chk({tag, "_addrs"}, {imem_addr, opr_addr, wb_addr, alu_op}, 0);
  endtask

  // Responder and compare process: every cycle, checks active requests against the model head.
  initial begin
    int k, nreq;
    txn_t h;
    imem_ack = 0; opr_ack = 0; wb_ack = 0; alu_done = 0; imem_data = '0;
    forever begin
      @(negedge clock);
      cyc++;
      imem_ack = 0; opr_ack = 0; wb_ack = 0; alu_done = 0;
      imem_data = {8{$urandom()}};
      if (!reset) begin
        if (stall_kind < 0) chk("no_fault", fault, 0);
        if (fault && t_fault < 0) t_fault = cyc;
        nreq = int'(imem_req) + int'(opr_req) + int'(wb_req) + int'(alu_start);
        if (nreq > 0) chk("one_active_unit", nreq, 1);
        if (alu_start) begin
          n_alu_cyc++;
          if (exp_q.size() == 0) chk("unexpected_alu_start", 1, 0);
          else begin
            h = exp_q[0];
            chk("alu_start_order", h.kind, 2);
            chk("alu_op_start", alu_op, h.op);
            void'(exp_q.pop_front());
          end
          alu_wait = 1;
          remain_alu = pick(2, 0);
        end
        if (alu_wait != 0) begin
          if (remain_alu == 0) begin
            alu_done = 1;
            alu_wait = 0;
          end else remain_alu--;
        end
        if (imem_req || opr_req || wb_req) begin
          k = imem_req ? 0 : (opr_req ? 1 : 3);
          if (busy == 0) begin
            busy = 1;
            remain = pick(k, int'(opr_sel));
          end
          if (k == 1 && !opr_sel) n_rd1_cyc++;
          if (exp_q.size() == 0) chk("unexpected_req", k, -1);
          else begin
            h = exp_q[0];
            chk("req_kind", k, h.kind);
            if (k == 0) chk("imem_addr", imem_addr, h.addr);
            if (k == 1) begin
              chk("opr_sel", opr_sel, h.sel);
              chk("opr_is_reg", opr_is_reg, h.is_reg);
              chk("opr_addr", opr_addr, h.addr);
              chk("alu_op_opr", alu_op, h.op);
            end
            if (k == 3) begin
              chk("wb_is_reg", wb_is_reg, h.is_reg);
              chk("wb_addr", wb_addr, h.addr);
              chk("alu_op_wb", alu_op, h.op);
            end
          end
          if (remain == 0) begin
            busy = 0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (k == 0) begin
              imem_ack = 1;
              imem_data = prog[imem_addr];
              if (n_fetch == 0) first_fetch_addr = int'(imem_addr);
              last_fetch_addr = int'(imem_addr);
              n_fetch++;
            end else if (k == 1) begin
              opr_ack = 1;
              if (opr_sel) n_opr1++; else n_opr0++;
            end else begin
              wb_ack = 1;
              last_wb_addr = int'(wb_addr);
              last_wb_is_reg = int'(wb_is_reg);
            end
          end else remain--;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cycles, h, saw;
    dly_max = 0;
    do_reset();
    chk_reset_outputs("reset");

    // ADD r3 <- r1, r2 then HALT, all acks immediate.
    prog[0] = '0; prog[1] = '0;
    set_slot(0, 0, enc(1, 1, 3, 1, 1, 1, 2, 1));
    set_slot(0, 1, HALT);
    start_run();
    wait_halt("add", 100, cycles);
    chk("add_latency", cycles, 7);
    chk("add_wb_addr", last_wb_addr, 3);
    chk("add_wb_is_reg", last_wb_is_reg, 1);
    chk("add_pc", pc, 1);
    chk("add_fetch_addr", first_fetch_addr, 0);
    end_checks("add");

    // Single-operand instruction skips RD2.
    do_reset();
    set_slot(0, 0, enc(5, 0, 9, 1, 17, 0, 33, 0));
    set_slot(0, 1, HALT);
    start_run();
    wait_halt("one_src", 100, cycles);
    chk("one_src_latency", cycles, 6);
    chk("one_src_opr0", n_opr0, 1);
    chk("one_src_opr1", n_opr1, 0);
    chk("one_src_alu_start_cycles", n_alu_cyc, 1);
    end_checks("one_src");

    // RD1 ack delayed 3 cycles: request held 4 cycles, ack in the timeout cycle wins.
    do_reset();
    set_slot(0, 0, enc(9, 1, 4, 0, 20, 1, 7, 1));
    set_slot(0, 1, HALT);
    force_rd1 = 3;
    start_run();
    wait_halt("rd1_wait", 100, cycles);
    chk("rd1_req_cycles", n_rd1_cyc, 4);
    chk("rd1_latency", cycles, 10);
    end_checks("rd1_wait");

    // Eight instructions then HALT in packet 1: second fetch at packet 1.
    do_reset();
    for (int s = 0; s < 8; s++) begin
      set_slot(0, s, rand_inst());
      set_slot(1, s, rand_inst());
    end
    set_slot(1, 0, HALT);
    start_run();
    wait_halt("pkt_cross", 300, cycles);
    chk("pkt_cross_fetches", n_fetch, 2);
    chk("pkt_cross_last_fetch", last_fetch_addr, 1);
    chk("pkt_cross_pc", pc, 8);
    end_checks("pkt_cross");

    // Resume from pc 8 through pc 15, wrap and refetch packet 0.
    for (int s = 0; s < 8; s++) begin
      set_slot(0, s, rand_inst());
      set_slot(1, s, rand_inst());
    end
    set_slot(0, 2, HALT);
    clear_stats();
    start_run();
    wait_halt("wrap", 300, cycles);
    chk("wrap_fetches", n_fetch, 2);
    chk("wrap_first_fetch", first_fetch_addr, 1);
    chk("wrap_last_fetch", last_fetch_addr, 0);
    chk("wrap_pc", pc, 2);
    end_checks("wrap");

    // Randomized programs and delays, plus a resume onto the HALT.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int s = 0; s < 8; s++) begin
        set_slot(0, s, rand_inst());
        set_slot(1, s, rand_inst());
      end
      h = int'($urandom_range(15, 0));
      set_slot(h / 8, h % 8, HALT);
      dly_max = int'($urandom_range(3, 0));
      start_run();
      wait_halt("rand", 600, cycles);
      chk("rand_halt_pc", pc, h);
      end_checks("rand");
      clear_stats();
      start_run();
      wait_halt("resume", 100, cycles);
      end_checks("resume");
    end

    // Timeout in each waiting unit leads to an absorbing fault.
    for (int k = 0; k < 4; k++) begin
      do_reset();
      set_slot(0, 0, enc(3, 1, 5, 0, 6, 1, 8, 1));
      set_slot(0, 1, HALT);
      dly_max = 1;
      stall_kind = k;
      start_run();
      cycles = 0;
      while (t_fault < 0 && cycles < 60) begin
        @(posedge clock);
        #1 cycles++;
      end
      chk("timeout_fault", fault, 1);
      chk("timeout_cycles", t_fault - t_stall, TOUT);
      chk("timeout_code", fault_code, k);
      chk("timeout_reqs_low", {imem_req, opr_req, wb_req, alu_start}, 0);
      run = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      chk("fault_run_ignored", fault, 1);
      chk("fault_not_halted", halted, 0);
      chk("fault_reqs_stay_low", {imem_req, opr_req, wb_req, alu_start}, 0);
      run = 1'b0;
      do_reset();
      chk("fault_cleared", fault, 0);
      chk("fault_code_cleared", fault_code, 0);
    end

    // Reset while a writeback is pending, then run again from packet 0.
    do_reset();
    dly_max = 0;
    set_slot(0, 0, enc(12, 1, 44, 1, 3, 0, 9, 1));
    set_slot(0, 1, HALT);
    force_wb = 3;
    start_run();
    cycles = 0;
    saw = 0;
    while (cycles < 50 && saw == 0) begin
      @(posedge clock);
      #1 cycles++;
      if (wb_req) saw = 1;
    end
    chk("midreset_saw_wb_req", saw, 1);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("midreset");
    do_reset();
    start_run();
    wait_halt("after_reset", 100, cycles);
    chk("after_reset_fetch_addr", first_fetch_addr, 0);
    chk("after_reset_fetches", n_fetch, 1);
    end_checks("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
